srv_bus_arb_v1: RTL

//  N-to-1 round-robin arbiter sharing one downstream bus port (feeding the address decoder) between
//  N_US upstream requesters (e.g. ifetch, LSU, debug). Holds the grant stable until the downstream

---
 rtl/srv_bus_arb_v1.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/srv_bus_arb_v1.sv
// Round-robin N-to-1 bus arbiter with grant hold and an in-order grant-ID FIFO
// that routes downstream responses back to the requester that issued them.

module srv_bus_arb_v1_lane #(
  parameter int IDX = 0,
  parameter int IDW = 1
) (
  input  logic [IDW-1:0] sel,
  input  logic [IDW-1:0] head,
  input  logic           accept,
  input  logic           rsp_fire,
  output logic           req_ready,
  output logic           rsp_valid
);
  localparam logic [IDW-1:0] ID = IDW'(IDX);

  assign req_ready = accept && (sel == ID);
  assign rsp_valid = rsp_fire && (head == ID);
endmodule

module srv_bus_arb_v1 #(
  parameter int N_US    = 2,
  parameter int MAX_OST = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_US-1:0]     us_req_valid,
  output logic [N_US-1:0]     us_req_ready,
  input  logic [N_US*32-1:0]  us_req_addr,
  input  logic [N_US-1:0]     us_req_wen,
  input  logic [N_US*32-1:0]  us_req_wdata,
  input  logic [N_US*4-1:0]   us_req_wstrb,
  output logic [N_US-1:0]     us_rsp_valid,
  output logic [31:0]         us_rsp_rdata,
  output logic                us_rsp_err,
  output logic                ds_req_valid,
  input  logic                ds_req_ready,
  output logic [31:0]         ds_req_addr,
  output logic                ds_req_wen,
  output logic [31:0]         ds_req_wdata,
  output logic [3:0]          ds_req_wstrb,
  input  logic                ds_rsp_valid,
  input  logic [31:0]         ds_rsp_rdata,
  input  logic                ds_rsp_err,
  output logic                proto_err
);
  localparam int IDW = (N_US > 1) ? $clog2(N_US) : 1;
  localparam int PW  = (MAX_OST > 1) ? $clog2(MAX_OST) : 1;
  localparam int CW  = $clog2(MAX_OST) + 1;

  typedef enum logic {ARB, HOLD} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] rr_ptr, gnt_id, winner, sel, head;
  logic [IDW-1:0] hi_idx, lo_idx;
  logic           hi_any, lo_any, any_req;
  logic [CW-1:0]  ost_cnt;
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [IDW-1:0] fifo [MAX_OST];
  logic           full, accept, rsp_fire;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OST - 1)) ? '0 : p + 1'b1;
  endfunction

  // Lowest valid index at/above rr_ptr wins; otherwise wrap to lowest valid overall.
  always_comb begin
    hi_idx = '0;
    lo_idx = '0;
    hi_any = 1'b0;
    lo_any = 1'b0;
    for (int i = N_US - 1; i >= 0; i--) begin
      if (us_req_valid[i]) begin
        lo_idx = IDW'(i);
        lo_any = 1'b1;
        if (IDW'(i) >= rr_ptr) begin
          hi_idx = IDW'(i);
          hi_any = 1'b1;
        end
      end
    end
    winner  = hi_any ? hi_idx : lo_idx;
    any_req = lo_any;
  end

  assign full = (ost_cnt == CW'(MAX_OST));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ARB;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB:  if (ds_req_valid && !ds_req_ready) state_nxt = HOLD;
      HOLD: if (ds_req_ready) state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
  end

  // HOLD bypasses the full gate: that request was admitted while there was room.
  always_comb begin
    ds_req_valid = 1'b0;
    sel          = winner;
    case (state)
      ARB:  ds_req_valid = !rst && any_req && !full;
      HOLD: begin
        ds_req_valid = 1'b1;
        sel          = gnt_id;
      end
      default: ;
    endcase
  end

  always_comb begin
    ds_req_addr  = '0;
    ds_req_wen   = 1'b0;
    ds_req_wdata = '0;
    ds_req_wstrb = '0;
    for (int i = 0; i < N_US; i++) begin
      if (sel == IDW'(i)) begin
        ds_req_addr  = us_req_addr[32*i +: 32];
        ds_req_wen   = us_req_wen[i];
        ds_req_wdata = us_req_wdata[32*i +: 32];
        ds_req_wstrb = us_req_wstrb[4*i +: 4];
      end
    end
  end

  assign accept       = ds_req_valid && ds_req_ready;
  assign rsp_fire     = !rst && ds_rsp_valid && (ost_cnt != '0);
  assign head         = fifo[rd_ptr];
  assign us_rsp_rdata = ds_rsp_rdata;
  assign us_rsp_err   = ds_rsp_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= '0;
      gnt_id    <= '0;
      ost_cnt   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      proto_err <= 1'b0;
    end else begin
      if (state == ARB && ds_req_valid && !ds_req_ready) gnt_id <= winner;
      if (accept) begin
        rr_ptr <= (sel == IDW'(N_US - 1)) ? '0 : sel + 1'b1;
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (rsp_fire) rd_ptr <= ptr_inc(rd_ptr);
      case ({accept, rsp_fire})
        2'b10:   ost_cnt <= ost_cnt + CW'(1);
        2'b01:   ost_cnt <= ost_cnt - CW'(1);
        default: ;
      endcase
      if (ds_rsp_valid && ost_cnt == '0) proto_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) fifo[wr_ptr] <= sel;
  end

  for (genvar g = 0; g < N_US; g++) begin : g_lane
    srv_bus_arb_v1_lane #(.IDX(g), .IDW(IDW)) u_lane (
      .sel       (sel),
      .head      (head),
      .accept    (accept),
      .rsp_fire  (rsp_fire),
      .req_ready (us_req_ready[g]),
      .rsp_valid (us_rsp_valid[g])
    );
  end
endmodule
